// File: rtl/uart_loader.sv
// uart_loader: parses A5/LEN/words/CHK frames from the UART and writes 16-bit words to memory.
// Optional inter-byte timeout is built when LOADER_TIMEOUT_EN is defined.
module uart_loader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int BASE_ADDR    = 0,
    parameter int TIMEOUT_CLKS = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data,
    output logic                  mem_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [7:0]            SYNC = 8'hA5;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_W_HI,
        S_W_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic                  r_rdy_q;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len_hi;
    logic [7:0]            r_hi;
    logic [7:0]            r_chk;
    logic [15:0]           r_count;

    logic                  w_stb;
    logic                  w_tmo;
    logic [15:0]           w_len;

    // rx_ready is a level; only its rising edge marks a new byte
    assign w_stb = rx_ready & ~r_rdy_q;
    assign w_len = {r_len_hi, rx_data};

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (!rst || w_stb || !busy) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo = busy && !w_stb && (r_tmo == TW'(TIMEOUT_CLKS - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rdy_q  <= 1'b0;
            r_addr   <= BASE;
            r_len_hi <= 8'h00;
            r_hi     <= 8'h00;
            r_chk    <= 8'h00;
            r_count  <= 16'h0000;
            mem_addr <= '0;
            mem_data <= 16'h0000;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_rdy_q <= rx_ready;
            mem_wr  <= 1'b0;
            if (w_tmo) begin
                r_state <= S_ERROR;
                busy    <= 1'b0;
                done    <= 1'b0;
                err     <= 1'b1;
            end else if (w_stb) begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_data == SYNC) begin
                            r_state <= S_LEN_HI;
                            r_addr  <= BASE;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                        end
                    end
                    S_LEN_HI: begin
                        r_len_hi <= rx_data;
                        r_chk    <= rx_data;
                        r_state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        r_chk   <= r_chk ^ rx_data;
                        r_count <= w_len;
                        r_state <= (w_len != 16'h0000) ? S_W_HI : S_CHECK;
                    end
                    S_W_HI: begin
                        r_hi    <= rx_data;
                        r_chk   <= r_chk ^ rx_data;
                        r_state <= S_W_LO;
                    end
                    S_W_LO: begin
                        r_chk    <= r_chk ^ rx_data;
                        mem_addr <= r_addr;
                        mem_data <= {r_hi, rx_data};
                        mem_wr   <= 1'b1;
                        r_addr   <= r_addr + 1'b1;
                        r_count  <= r_count - 16'd1;
                        r_state  <= (r_count == 16'd1) ? S_CHECK : S_W_HI;
                    end
                    S_CHECK: begin
                        busy <= 1'b0;
                        if (rx_data == r_chk) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            err     <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: frame vectors plus write scoreboard for uart_loader.
// Build with LOADER_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_uart_loader;
    localparam int AW = 2;

`ifdef LOADER_TIMEOUT_EN
    localparam int LONG = 30;
`else
    localparam int LONG = 100;
`endif

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_wr;
    logic          busy;
    logic          done;
    logic          err;

    uart_loader #(
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (0),
        .TIMEOUT_CLKS(50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wr  (mem_wr),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] b;
        int           nb;
        int           hold;
        logic [191:0] w;
        int           nw;
        logic         e_done;
        logic         e_err;
    } vec_t;

    vec_t        vt [7];
    logic [23:0] exp_q [$];
    logic [23:0] obs_q [$];
    int          n_vec = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        if (mem_wr) obs_q.push_back({6'b0, mem_addr, mem_data});
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_writes(input string nm);
        check({nm, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({nm, "_wr"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_addr"}, 32'(mem_addr), 32'h0);
        check({nm, "_data"}, 32'(mem_data), 32'h0);
        check({nm, "_wr"},   32'(mem_wr),   32'h0);
        check({nm, "_busy"}, 32'(busy),     32'h0);
        check({nm, "_done"}, 32'(done),     32'h0);
        check({nm, "_err"},  32'(err),      32'h0);
    endtask

    task automatic happy_frame();
        exp_q.push_back(24'h001234);
        exp_q.push_back(24'h01ABCD);
        send(8'hA5, 1); send(8'h00, 1); send(8'h02, 1);
        send(8'h12, 1); send(8'h34, 1); send(8'hAB, 1);
        send(8'hCD, 1); send(8'h42, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{b: 128'({8'h00, 8'hFF, 8'h5A}), nb: 3, hold: 1,
                  w: '0, nw: 0, e_done: 1'b0, e_err: 1'b0};
        vt[1] = '{b: 128'({8'hA5, 8'h00, 8'h00, 8'h00}), nb: 4, hold: 1,
                  w: '0, nw: 0, e_done: 1'b1, e_err: 1'b0};
        vt[2] = '{b: 128'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB,
                           8'hCD, 8'h42}), nb: 8, hold: 1,
                  w: 192'({24'h001234, 24'h01ABCD}), nw: 2,
                  e_done: 1'b1, e_err: 1'b0};
        vt[3] = '{b: 128'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB,
                           8'hCD, 8'h43}), nb: 8, hold: 1,
                  w: 192'({24'h001234, 24'h01ABCD}), nw: 2,
                  e_done: 1'b0, e_err: 1'b1};
        vt[4] = '{b: 128'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB,
                           8'hCD, 8'h42}), nb: 8, hold: LONG,
                  w: 192'({24'h001234, 24'h01ABCD}), nw: 2,
                  e_done: 1'b1, e_err: 1'b0};
        vt[5] = '{b: 128'({8'hA5, 8'h00, 8'h05, 8'h01, 8'h00, 8'h02,
                           8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05,
                           8'h00, 8'h04}), nb: 14, hold: 1,
                  w: 192'({24'h000100, 24'h010200, 24'h020300,
                           24'h030400, 24'h000500}), nw: 5,
                  e_done: 1'b1, e_err: 1'b0};
        vt[6] = '{b: 128'({8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01}),
                  nb: 6, hold: 1, w: 192'(24'h00A5A5), nw: 1,
                  e_done: 1'b1, e_err: 1'b0};

        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vt[i].nw; j++)
                exp_q.push_back(vt[i].w[24*(vt[i].nw-1-j) +: 24]);
            for (int j = 0; j < vt[i].nb; j++)
                send(vt[i].b[8*(vt[i].nb-1-j) +: 8], vt[i].hold);
            check($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].e_done));
            check($sformatf("v%0d_err", i),  32'(err),  32'(vt[i].e_err));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            check_writes($sformatf("v%0d", i));
        end

        // restart from DONE: done clears as soon as LEN_HI is entered
        send(8'hA5, 1);
        check("restart_done", 32'(done), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        check("restart_err",  32'(err),  32'h0);
        exp_q.push_back(24'h007788);
        send(8'h00, 1); send(8'h01, 1);
        send(8'h77, 1); send(8'h88, 1);
        send(8'hFE, 1);
        check("restart_fin_done", 32'(done), 32'h1);
        check_writes("restart");

        // reset after the high byte of the first word
        send(8'hA5, 1); send(8'h00, 1);
        send(8'h03, 1); send(8'h12, 1);
        check("midrst_busy_pre", 32'(busy), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b1;
        send(8'h34, 1);
        repeat (4) @(negedge clk);
        check("midrst_busy_post", 32'(busy), 32'h0);
        check_writes("midrst");
        happy_frame();
        check("midrst_reload_done", 32'(done), 32'h1);
        check("midrst_reload_err",  32'(err),  32'h0);
        check_writes("midrst_reload");

        // stall after LEN_LO
        send(8'hA5, 1); send(8'h00, 1); send(8'h01, 1);
        repeat (40) @(negedge clk);
        check("stall_busy_early", 32'(busy), 32'h1);
        check("stall_err_early",  32'(err),  32'h0);
        repeat (10) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        check("tmo_err",  32'(err),  32'h1);
        check("tmo_busy", 32'(busy), 32'h0);
`else
        check("stall_busy_late", 32'(busy), 32'h1);
        check("stall_err_late",  32'(err),  32'h0);
`endif
        check_writes("stall");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Sits directly downstream of the UART receiver and consumes its byte output (`data` and `data_ready`).
- Parses a framed program-load stream, assembles big-endian 16-bit words and writes them sequentially into instruction/data memory.
- Verifies an XOR checksum at the end of the frame and reports done or error status to the boot/reset controller.

Parameters:
- ADDR_WIDTH, 10: memory address width; also the width of the word address counter.
- BASE_ADDR, 0: address of the first word written in each frame.
- TIMEOUT_CLKS, 500000: inter-byte timeout in clk cycles. Used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_ready  in  1  byte-valid level from the UART receiver. It rises when a byte completes and stays high until the next start bit.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  16  write data.
- mem_wr  out  1  write strobe, single-cycle pulse.
- busy  out  1  high while a frame is in progress.
- done  out  1  frame loaded and checksum OK; level.
- err  out  1  frame failed; level.

Behaviour:
- Byte strobe:
  - rx_ready is registered into rdy_q.
  - byte_stb = rx_ready & ~rdy_q.
  - rx_data is sampled on the clk edge where byte_stb = 1.
  - A level held high yields exactly one strobe.
- Frame format, in byte order:
  - 0xA5 sync.
  - LEN_HI, LEN_LO: N = word count, 16 bits.
  - N x (W_HI, W_LO).
  - CHK = XOR of all bytes from LEN_HI through the last W_LO inclusive.
- States: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CHECK, DONE, ERROR. Each transition below occurs on a byte_stb.
  - IDLE: 0xA5 -> LEN_HI. Any other byte is ignored and the state stays IDLE.
  - LEN_HI -> LEN_LO. Store the byte, init chk = byte.
  - LEN_LO -> W_HI if N != 0, else -> CHECK. chk ^= byte.
  - W_HI -> W_LO. Hold hi byte, chk ^= byte.
  - W_LO: chk ^= byte, then issue a write.
    - Next state is CHECK when the remaining count hits 0, else W_HI.
  - CHECK: if byte == chk -> DONE, else -> ERROR.
  - DONE / ERROR: 0xA5 -> LEN_HI (restart). Other bytes are ignored.
- Write timing:
  - On the clk edge capturing W_LO, mem_addr <= addr, mem_data <= {hi, lo}, and mem_wr <= 1 for the following cycle only.
  - addr increments after each write.
  - addr reloads to BASE_ADDR on entry to LEN_HI.
- Address wrap:
  - addr increments modulo 2^ADDR_WIDTH.
  - N larger than the memory is legal and overwrites earlier words; no error is raised.
- Status outputs (all registered):
  - busy = 1 in LEN_HI..CHECK.
  - done = 1 only in DONE.
  - err = 1 only in ERROR.
  - Entering LEN_HI clears done and err in the same edge.
- Reset values: mem_addr = 0, mem_data = 0, mem_wr = 0, busy = 0, done = 0, err = 0, rdy_q = 0, state IDLE, addr = BASE_ADDR, chk = 0, count = 0.
- Reset mid-frame:
  - Return to IDLE immediately.
  - Words already written stay in memory.
  - No pending mem_wr is issued.
- A 0xA5 byte inside a frame is data, not a resync.
- A byte_stb in the same cycle that mem_wr is high is processed normally. Two consecutive strobes are at least 2 cycles apart, because rx_ready must fall first.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter clears on every byte_stb and increments each cycle while busy = 1.
  - Reaching TIMEOUT_CLKS forces ERROR (err = 1, busy = 0).
  - The counter is inactive outside busy.
- Undefined:
  - No counter logic is built.
  - A stalled frame waits indefinitely with busy = 1.

Test Plan:
- Happy path, BASE_ADDR = 0. Send A5 00 02 12 34 AB CD, then CHK = 00^02^12^34^AB^CD = 0x42.
  - Required: mem_wr pulses twice, (0, 0x1234) then (1, 0xABCD).
  - Then done = 1, err = 0, busy = 0.
- Bad checksum: same frame with CHK = 0x43.
  - Required: both writes still occur, then err = 1, done = 0.
- Noise and zero length:
  - Bytes 00 FF 5A are ignored: no busy, no mem_wr.
  - Then A5 00 00 00 gives done = 1 with zero writes.
- Level hold and restart:
  - rx_ready held high for 100 cycles per byte gives one strobe per byte.
  - From DONE, a new A5 frame clears done at LEN_HI and restarts addr at BASE_ADDR.
- Reset mid-frame: drop rst after A5 00 03 12.
  - Required: all outputs return to reset values, and no mem_wr follows.
  - The next full frame then loads correctly.
- Wrap (ADDR_WIDTH = 2): N = 5 gives write addresses 0, 1, 2, 3, 0.
  - With LOADER_TIMEOUT_EN and TIMEOUT_CLKS = 50, stalling after LEN_LO gives err = 1 at cycle 50.
